mem_access: RTL
===============

Name: mem_access

Overview:
- MEM stage of the RV32I pipeline, directly downstream of the ALU stage.
- Registers the ALU stage outputs and performs loads and stores over a simple req/ready data-bus handshake.
- Stalls the upstream pipeline while an access is pending.
- Drives the writeback stage and the FWD_M_* forwarding path back into the ALU stage.

Parameters:
- ADDR_W, 32, data-bus address width; the low 2 bits are forced to 0 on the bus.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- A_PC  in  32  PC from ALU stage
- A_INST  in  32  instruction from ALU stage
- A_VALID  in  1  ALU-stage slot holds a valid instruction
- A_REG_D  in  5  destination register
- A_REG_D_V  in  32  ALU result; doubles as the load/store effective address
- A_MEM_RE  in  1  instruction is a load
- A_MEM_WE  in  1  instruction is a store
- A_FUNCT3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010)
- A_STORE_DATA  in  32  rs2 value (already forwarded) for stores
- MEM_REQ  out  1  bus request
- MEM_WE  out  1  1 = write
- MEM_ADDR  out  ADDR_W  word-aligned address
- MEM_STRB  out  4  byte enables
- MEM_WDATA  out  32  lane-aligned write data
- MEM_READY  in  1  bus completes the access this cycle
- MEM_RDATA  in  32  read word, valid when MEM_READY=1
- M_STALL  out  1  hold upstream stages (connect to ALU STALL)
- M_PC  out  32  to writeback
- M_INST  out  32  to writeback
- M_VALID  out  1  to writeback
- M_REG_D  out  5  to writeback
- M_REG_D_V  out  32  to writeback
- M_MISALIGN  out  1  1-cycle flag: misaligned access was dropped
- FWD_M_VALID  out  1  M_VALID && M_REG_D != 0
- FWD_M_REG_D  out  5  equals M_REG_D
- FWD_M_REG_D_V  out  32  equals M_REG_D_V

Behaviour:
- Reset (RST=0, async): state=IDLE; all stage registers=0; MEM_REQ=0, M_STALL=0, M_VALID=0, M_MISALIGN=0. A reset mid-access drops MEM_REQ immediately and the access is abandoned.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE, rising edge: latch all A_* inputs.
    - If A_VALID and (A_MEM_RE or A_MEM_WE) and the address is aligned: next=BUSY.
    - Otherwise: next=IDLE.
  - BUSY, MEM_READY=1: capture read data; next=DONE.
  - BUSY, MEM_READY=0: stay in BUSY.
- M_STALL = (state==BUSY), combinational. No A_* latch occurs in BUSY.
- Output timing:
  - Non-memory instruction: M_* valid the cycle after the latch (1-cycle latency, no stall).
  - Memory instruction: M_VALID=0 in BUSY; M_VALID=1 in DONE (latency = 1 + wait cycles + 1).
- Bus: in BUSY, MEM_REQ=1. MEM_WE, MEM_ADDR, MEM_STRB and MEM_WDATA stay stable until MEM_READY. MEM_READY outside BUSY is ignored.
- Strobes:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
- Write data: the byte/half is replicated across all lanes.
- Load result: select the lane by addr[1:0]; sign- or zero-extend per funct3.
- M_REG_D_V and M_REG_D:
  - M_REG_D_V = load result for loads, latched A_REG_D_V otherwise.
  - Forced to 0 when M_REG_D == 0.
  - Stores present M_REG_D = 0.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0):
  - No bus access is made.
  - Output follows the non-memory timing, with M_VALID=1, M_REG_D=0 and M_MISALIGN=1 for that cycle.
- Invalid slot (A_VALID=0): no bus access, M_VALID=0; RE/WE are ignored.
- Unsupported funct3 (011, 11x): treated as a word access.
- Back-to-back memory ops: the DONE cycle latches the next op, so the next BUSY follows immediately after DONE.

Test Plan:
- ALU op with A_VALID=1, rd=5, value 0x1234 → next cycle M_VALID=1, M_REG_D_V=0x1234, FWD_M_VALID=1, M_STALL never 1.
- LB at addr 0x1003; RDATA 0x80FF_FF00 returned after 3 wait cycles:
  - MEM_ADDR=0x1000, STRB=1000.
  - M_STALL high for 4 cycles.
  - DONE shows M_REG_D_V=0xFFFF_FF80.
  - LBU of the same access yields 0x80.
- SH at addr 0x2002, data 0xABCD → MEM_WE=1, STRB=1100, WDATA=0xABCD_ABCD; DONE shows M_REG_D=0, FWD_M_VALID=0.
- LW at addr 0x3001 → no MEM_REQ, M_MISALIGN=1 for one cycle, M_REG_D=0.
- Two consecutive LW, each with immediate ready:
  - Sequence is BUSY, DONE, BUSY, DONE.
  - Both results are correct.
  - The upstream instruction is held across each BUSY.
- RST low during BUSY → MEM_REQ=0 in the same cycle; after release, state IDLE with all outputs 0; a later MEM_READY is ignored.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: registers the ALU-stage slot, runs loads/stores over a
// req/ready data bus, stalls upstream while an access is outstanding, and feeds writeback.
module mem_access #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       A_PC,
    input  logic [31:0]       A_INST,
    input  logic              A_VALID,
    input  logic [4:0]        A_REG_D,
    input  logic [31:0]       A_REG_D_V,
    input  logic              A_MEM_RE,
    input  logic              A_MEM_WE,
    input  logic [2:0]        A_FUNCT3,
    input  logic [31:0]       A_STORE_DATA,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_STRB,
    output logic [31:0]       MEM_WDATA,
    input  logic              MEM_READY,
    input  logic [31:0]       MEM_RDATA,
    output logic              M_STALL,
    output logic [31:0]       M_PC,
    output logic [31:0]       M_INST,
    output logic              M_VALID,
    output logic [4:0]        M_REG_D,
    output logic [31:0]       M_REG_D_V,
    output logic              M_MISALIGN,
    output logic              FWD_M_VALID,
    output logic [4:0]        FWD_M_REG_D,
    output logic [31:0]       FWD_M_REG_D_V
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] val_q, val_d;
    logic        ld_q, ld_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] sdata_q, sdata_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;

    logic        a_mem;
    logic        a_mis;
    logic        busy;
    logic [1:0]  off;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [4:0]  out_rd;

    // Funct3 low bits: 00 byte, 01 half, anything else is a word access.
    always_comb begin
        a_mem = A_VALID && (A_MEM_RE || A_MEM_WE);
        a_mis = a_mem && (((A_FUNCT3[1:0] == 2'b01) && A_REG_D_V[0]) ||
                          (A_FUNCT3[1] && (A_REG_D_V[1:0] != 2'b00)));
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        rd_d    = rd_q;
        val_d   = val_q;
        ld_d    = ld_q;
        st_d    = st_q;
        f3_d    = f3_q;
        sdata_d = sdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle, StDone: begin
                pc_d    = A_PC;
                inst_d  = A_INST;
                valid_d = A_VALID;
                rd_d    = A_REG_D;
                val_d   = A_REG_D_V;
                ld_d    = A_VALID && A_MEM_RE && !A_MEM_WE;
                st_d    = A_VALID && A_MEM_WE;
                f3_d    = A_FUNCT3;
                sdata_d = A_STORE_DATA;
                mis_d   = a_mis;
                state_d = (a_mem && !a_mis) ? StBusy : StIdle;
            end
            StBusy: begin
                if (MEM_READY) begin
                    rdata_d = MEM_RDATA;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            rd_q    <= '0;
            val_q   <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            f3_q    <= '0;
            sdata_q <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
            val_q   <= val_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            sdata_q <= sdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus side: everything is derived from the held slot, so it is stable for the whole BUSY.
    always_comb begin
        busy     = (state_q == StBusy);
        off      = val_q[1:0];
        MEM_REQ  = busy;
        M_STALL  = busy;
        MEM_WE   = busy && st_q;
        MEM_ADDR = {val_q[ADDR_W-1:2], 2'b00};
        case (f3_q[1:0])
            2'b00: begin
                MEM_STRB  = 4'b0001 << off;
                MEM_WDATA = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                MEM_STRB  = 4'b0011 << off;
                MEM_WDATA = {2{sdata_q[15:0]}};
            end
            default: begin
                MEM_STRB  = 4'b1111;
                MEM_WDATA = sdata_q;
            end
        endcase
        if (!busy) begin
            MEM_STRB = 4'b0000;
        end
    end

    // Load lane select and extension; funct3[2] set means zero-extend.
    always_comb begin
        lane = rdata_q >> {off, 3'b000};
        case (f3_q[1:0])
            2'b00:   load_val = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        out_rd        = (st_q || mis_q) ? 5'd0 : rd_q;
        M_PC          = pc_q;
        M_INST        = inst_q;
        M_VALID       = (state_q == StDone) || ((state_q == StIdle) && valid_q);
        M_REG_D       = out_rd;
        M_REG_D_V     = (out_rd == 5'd0) ? 32'd0 : (ld_q ? load_val : val_q);
        M_MISALIGN    = mis_q;
        FWD_M_VALID   = M_VALID && (out_rd != 5'd0);
        FWD_M_REG_D   = out_rd;
        FWD_M_REG_D_V = M_REG_D_V;
    end

endmodule
